// File: rtl/asm_acc_stage.sv
// asm_acc_stage: sums a variable-length vector of unsigned products into one result.
// Build option ASM_ACC_SAT_EN: clamp the sum on overflow instead of wrapping.
module asm_acc_stage #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 2*WIDTH+8,
  parameter int MAX_TERMS = 256,
  parameter int CNT_WIDTH = $clog2(MAX_TERMS+1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 prod_valid,
  output logic                 prod_ready,
  input  logic [2*WIDTH-1:0]   prod_data,
  input  logic                 prod_first,
  input  logic                 prod_last,
  output logic                 acc_valid,
  input  logic                 acc_ready,
  output logic [ACC_WIDTH-1:0] acc_data,
  output logic [CNT_WIDTH-1:0] acc_count,
  output logic                 acc_ovf,
  output logic                 acc_trunc
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_e;

  localparam logic [CNT_WIDTH-1:0] MAX_C = CNT_WIDTH'(MAX_TERMS);
  localparam logic [CNT_WIDTH-1:0] ONE_C = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] sum_q, sum_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 trunc_q, trunc_d;

  logic [ACC_WIDTH-1:0] prod_z;
  logic [ACC_WIDTH:0]   add_w;
  logic                 beat;
  logic                 load;
  logic                 full;

  assign prod_z = ACC_WIDTH'(prod_data);
  assign add_w  = {1'b0, sum_q} + {1'b0, prod_z};
  assign beat   = prod_valid & (state_q != HOLD);
  assign load   = (state_q == IDLE) | prod_first;

  // Next-state: load/add on accepted beats, close into HOLD, drain on acc_ready.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    trunc_d = trunc_q;
    full    = 1'b0;
    unique case (state_q)
      IDLE, ACCUM: begin
        if (beat) begin
          if (load) begin
            sum_d = prod_z;
            cnt_d = ONE_C;
            ovf_d = 1'b0;
          end else begin
            cnt_d = cnt_q + ONE_C;
            ovf_d = ovf_q | add_w[ACC_WIDTH];
`ifdef ASM_ACC_SAT_EN
            sum_d = add_w[ACC_WIDTH] ? {ACC_WIDTH{1'b1}}
                                     : add_w[ACC_WIDTH-1:0];
`else
            sum_d = add_w[ACC_WIDTH-1:0];
`endif
          end
          full    = (cnt_d == MAX_C);
          trunc_d = full & ~prod_last;
          state_d = (prod_last | full) ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (acc_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sum_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      trunc_q <= trunc_d;
    end
  end

  assign prod_ready = (state_q != HOLD);
  assign acc_valid  = (state_q == HOLD);
  assign acc_data   = sum_q;
  assign acc_count  = cnt_q;
  assign acc_ovf    = ovf_q;
  assign acc_trunc  = trunc_q;

endmodule

// File: tb/tb_asm_acc_stage.sv
// tb_asm_acc_stage: directed table plus randomized run against a queue model.
// Runs with WIDTH=8, ACC_WIDTH=17, MAX_TERMS=4.
module tb_asm_acc_stage;

  localparam int W   = 8;
  localparam int AW  = 17;
  localparam int MT  = 4;
  localparam int CW  = 3;
  localparam longint LIM = 131072;
`ifdef ASM_ACC_SAT_EN
  localparam int OVF_RES = 131071;
  localparam bit SAT = 1'b1;
`else
  localparam int OVF_RES = 64003;
  localparam bit SAT = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          prod_valid;
  logic          prod_ready;
  logic [2*W-1:0] prod_data;
  logic          prod_first;
  logic          prod_last;
  logic          acc_valid;
  logic          acc_ready;
  logic [AW-1:0] acc_data;
  logic [CW-1:0] acc_count;
  logic          acc_ovf;
  logic          acc_trunc;

  asm_acc_stage #(
    .WIDTH(W), .ACC_WIDTH(AW), .MAX_TERMS(MT), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .prod_valid(prod_valid), .prod_ready(prod_ready),
    .prod_data(prod_data), .prod_first(prod_first),
    .prod_last(prod_last),
    .acc_valid(acc_valid), .acc_ready(acc_ready),
    .acc_data(acc_data), .acc_count(acc_count),
    .acc_ovf(acc_ovf), .acc_trunc(acc_trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic r, v, f, l, rdy;
    int   d;
    logic e_pr, e_av, full;
    int   e_data, e_cnt;
    logic e_ovf, e_tr;
  } vec_t;

  vec_t vecs[$];

  function automatic void row(logic r, logic v, logic f, logic l,
                              logic rdy, int d, logic pr, logic av,
                              logic fl, int ed, int ec, logic eo,
                              logic et);
    vec_t x;
    x.r = r; x.v = v; x.f = f; x.l = l; x.rdy = rdy; x.d = d;
    x.e_pr = pr; x.e_av = av; x.full = fl;
    x.e_data = ed; x.e_cnt = ec; x.e_ovf = eo; x.e_tr = et;
    vecs.push_back(x);
  endfunction

  task automatic drive(logic r, logic v, int d, logic f, logic l,
                       logic rdy);
    rst_n      = r;
    prod_valid = v;
    prod_data  = d[2*W-1:0];
    prod_first = f;
    prod_last  = l;
    acc_ready  = rdy;
  endtask

  // Reference model: a queue of the current vector's terms.
  bit     m_pend;
  longint m_q[$];
  longint e_sum;
  int     e_cnt;
  bit     e_ovf, e_tr;

  task automatic model_step(logic r, logic v, int d, logic f, logic l,
                            logic rdy);
    longint tot;
    if (!r) begin
      m_pend = 0;
      m_q.delete();
    end else if (m_pend) begin
      if (rdy) begin
        m_pend = 0;
        m_q.delete();
      end
    end else if (v) begin
      if (m_q.size() == 0 || f) begin
        m_q.delete();
        m_q.push_back(longint'(d));
      end else begin
        m_q.push_back(longint'(d));
      end
      if (l || m_q.size() == MT) begin
        tot = 0;
        foreach (m_q[k]) tot += m_q[k];
        m_pend = 1;
        e_cnt  = m_q.size();
        e_tr   = (m_q.size() == MT) && !l;
        e_ovf  = (tot >= LIM);
        if (SAT) e_sum = e_ovf ? LIM - 1 : tot;
        else     e_sum = tot % LIM;
      end
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Reset held two edges with a beat offered.
    drive(0, 1, 99, 1, 1, 0);
    repeat (2) @(negedge clk);
    chk("rst prod_ready", prod_ready, 1);
    chk("rst acc_valid", acc_valid, 0);
    chk("rst acc_data", acc_data, 0);
    chk("rst acc_count", acc_count, 0);
    chk("rst acc_ovf", acc_ovf, 0);
    chk("rst acc_trunc", acc_trunc, 0);
    drive(1, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("rst no beat valid", acc_valid, 0);
    chk("rst no beat data", acc_data, 0);

    // Basic vector 10,20,30,40.
    row(1,1,1,0,1, 10, 1,0,0, 0,0,0,0);
    row(1,1,0,0,1, 20, 1,0,0, 0,0,0,0);
    row(1,1,0,0,1, 30, 1,0,0, 0,0,0,0);
    row(1,1,0,1,1, 40, 0,1,1, 100,4,0,0);
    row(1,0,0,0,1,  0, 1,0,0, 0,0,0,0);
    // Single beat under backpressure.
    row(1,1,1,1,0,  5, 0,1,1, 5,1,0,0);
    for (int i = 0; i < 4; i++)
      row(1,0,0,0,0, 0, 0,1,1, 5,1,0,0);
    row(1,0,0,0,1,  0, 1,0,0, 0,0,0,0);
    // Restart mid-vector.
    row(1,1,1,0,1,  7, 1,0,0, 0,0,0,0);
    row(1,1,0,0,1,  8, 1,0,0, 0,0,0,0);
    row(1,1,1,0,1,  3, 1,0,0, 0,0,0,0);
    row(1,1,0,1,1,  4, 0,1,1, 7,2,0,0);
    row(1,0,0,0,1,  0, 1,0,0, 0,0,0,0);
    // Overflow.
    row(1,1,1,0,1, 65025, 1,0,0, 0,0,0,0);
    row(1,1,0,0,1, 65025, 1,0,0, 0,0,0,0);
    row(1,1,0,1,1, 65025, 0,1,1, OVF_RES,3,1,0);
    row(1,0,0,0,1,  0, 1,0,0, 0,0,0,0);
    // Truncation at MAX_TERMS, then beats start a new vector.
    row(1,1,1,0,1,  1, 1,0,0, 0,0,0,0);
    row(1,1,0,0,1,  1, 1,0,0, 0,0,0,0);
    row(1,1,0,0,1,  1, 1,0,0, 0,0,0,0);
    row(1,1,0,0,1,  1, 0,1,1, 4,4,0,1);
    row(1,1,0,0,1,  1, 1,0,0, 0,0,0,0);
    row(1,1,0,0,1,  1, 1,0,0, 0,0,0,0);
    row(1,1,0,0,1,  1, 1,0,0, 0,0,0,0);
    row(1,1,0,1,1,  5, 0,1,1, 7,3,0,0);
    row(1,0,0,0,1,  0, 1,0,0, 0,0,0,0);
    // Reset mid-vector.
    row(1,1,1,0,1,  1, 1,0,0, 0,0,0,0);
    row(1,1,0,0,1,  2, 1,0,0, 0,0,0,0);
    row(0,1,0,0,1,  3, 1,0,1, 0,0,0,0);
    row(1,1,0,0,1,  1, 1,0,0, 0,0,0,0);
    row(1,1,0,0,1,  2, 1,0,0, 0,0,0,0);
    row(1,1,0,1,1,  3, 0,1,1, 6,3,0,0);
    row(1,0,0,0,1,  0, 1,0,0, 0,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].f,
            vecs[i].l, vecs[i].rdy);
      @(negedge clk);
      chk($sformatf("row%0d prod_ready", i), prod_ready, vecs[i].e_pr);
      chk($sformatf("row%0d acc_valid", i), acc_valid, vecs[i].e_av);
      if (vecs[i].full) begin
        chk($sformatf("row%0d acc_data", i), acc_data, vecs[i].e_data);
        chk($sformatf("row%0d acc_count", i), acc_count, vecs[i].e_cnt);
        chk($sformatf("row%0d acc_ovf", i), acc_ovf, vecs[i].e_ovf);
        chk($sformatf("row%0d acc_trunc", i), acc_trunc, vecs[i].e_tr);
      end
    end

    // Randomized traffic against the model.
    drive(0, 0, 0, 0, 0, 0);
    model_step(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    for (int c = 0; c < 3000; c++) begin
      logic v, f, l, rdy;
      int   d;
      v   = ($urandom_range(0, 99) < 75);
      f   = ($urandom_range(0, 5) == 0);
      l   = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 99) < 65);
      d   = ($urandom_range(0, 2) == 0) ? 65025
                                        : int'($urandom_range(0, 65535));
      drive(1, v, d, f, l, rdy);
      model_step(1, v, d, f, l, rdy);
      @(negedge clk);
      chk("rnd prod_ready", prod_ready, !m_pend);
      chk("rnd acc_valid", acc_valid, m_pend);
      if (m_pend) begin
        chk("rnd acc_data", acc_data, e_sum);
        chk("rnd acc_count", acc_count, e_cnt);
        chk("rnd acc_ovf", acc_ovf, e_ovf);
        chk("rnd acc_trunc", acc_trunc, e_tr);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
